le18_port_arb: RTL
==================

Name: le18_port_arb

Overview:
- Owns port A of the LE18 graphics RAM (14-bit address {y[7:0], x[5:0]}, 6-bit data, output-register read latency of 2).
- Shares that port between Z80 single-byte I/O accesses, decoded upstream, and a hardware fill engine. The fill engine writes a constant value into a range of LE18 rows, e.g. for a fast clear screen.
- Sits between the Z80 port-EC decode logic and the RAM instance, in the clk domain.

Parameters:
- DW, 6, RAM data width.
- XW, 6, column address width (64 bytes per row).
- Y_MAX, 191, last valid LE18 row.

Ports:
- clk  in  1  system clock.
- srst  in  1  synchronous active-high reset.
- z80_req  in  1  one-cycle access request pulse.
- z80_we  in  1  1=write, 0=read; qualifies z80_req.
- z80_addr  in  14  {y, x} for the request.
- z80_din  in  DW  write data.
- z80_dout  out  DW  read data; valid when z80_rdy=1.
- z80_rdy  out  1  one-cycle read-complete pulse.
- fill_start  in  1  one-cycle pulse that starts a fill.
- fill_val  in  DW  fill value, sampled on fill_start.
- fill_y0  in  8  first row, sampled on fill_start.
- fill_y1  in  8  last row (inclusive), sampled on fill_start.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse when a fill completes.
- ram_ce  out  1  port A enable.
- ram_we  out  1  port A write enable.
- ram_addr  out  14  port A address.
- ram_din  out  DW  port A write data.
- ram_oce  out  1  port A output-register enable.
- ram_dout  in  DW  port A read data.

Behaviour:
- Reset (srst=1), values after the reset edge:
  - All outputs 0; state IDLE.
  - Pending-request and read pipeline cleared.
  - An in-flight fill is aborted and produces no fill_done.
- Z80 has absolute priority. Z80 requests are never dropped; the fill engine only uses free cycles.
- Z80 request path:
  - A Z80 request is issued on cycle T when the port is free. Issue drives ram_ce=1, ram_addr=z80_addr, and for writes ram_we=1 and ram_din=z80_din. Issue is combinational from z80_req or from the pending register.
  - Read pipeline: T ce; T+1 ram_oce=1; T+2 z80_rdy=1 with z80_dout=ram_dout. z80_dout is registered and held until the next read completes.
  - Read pipeline busy window is T+1..T+2. During this window no port A ce is issued by anyone. Write-first mode would otherwise disturb the output latch.
  - A z80_req that arrives while the port is blocked is captured in a 1-deep pending register (we, addr, din). It is issued on the first free cycle.
  - A further z80_req while pending is full is a protocol violation: the newest request overwrites pending. Verify with an assertion; it is not required to work.
  - Writes complete in one cycle and block nothing afterwards.
- Fill FSM states: IDLE, FILL, DONE.
  - IDLE -> FILL on fill_start.
    - Latch fill_val. Set y = min(fill_y0, Y_MAX), yend = min(fill_y1, Y_MAX), x = 0.
    - If y > yend, go to DONE directly with no writes.
  - FILL: on each cycle where no Z80 issue occurs and the read pipeline is idle:
    - Drive ram_ce=1, ram_we=1, ram_addr={y, x}, ram_din=fill_val.
    - Then x increments. On x wrap 63->0, y increments.
    - After writing {yend, 63}, go to DONE.
  - Stalled cycles do not advance x or y.
  - DONE: fill_done=1 for one cycle, then IDLE.
  - fill_busy=1 in FILL and DONE.
  - fill_start while fill_busy=1 is ignored.
- A full-screen fill (rows 0..191, 12288 writes) takes 12288 + 1 cycles with no Z80 traffic. Each Z80 write adds 1 stall cycle; each Z80 read adds 3.
- Simultaneous z80_req and fill write-eligible cycle: Z80 issues, fill stalls.
- Simultaneous z80_req and fill_start in IDLE: Z80 issues; the fill latches, and its first write occurs on the next free cycle.
- Z80 writes into the fill range during a fill may be overwritten later by the fill. This is accepted behaviour, and software must wait for fill_busy=0.
- ram_oce=0 on every cycle except the T+1 of a Z80 read.

Test Plan:
- Reset, then Z80 write z80_addr=0x0041, din=0x15, followed by a read of 0x0041 -> ram_ce/ram_we for exactly 1 cycle on the write. On the read, ram_oce at T+1, z80_rdy at T+2, z80_dout=0x15.
- fill_start with y0=2, y1=3, val=0x3F, no Z80 traffic -> 128 consecutive writes to addresses 0x0080..0x00FF, all din=0x3F. fill_done pulses on the cycle after the write to 0x00FF; fill_busy high for 129 cycles.
- During that fill, Z80 reads at cycles 10 and 11 (second read goes to pending) -> both reads complete, with z80_rdy at T+2 and T+5. No ram_ce appears in the read-busy windows. Total fill time grows by 6 cycles. Address sequence is unbroken.
- fill_start with y0=5, y1=4 -> zero writes; fill_done pulses 1 cycle after start.
- fill_start with y0=190, y1=250 -> clamped to rows 190..191: 128 writes, last address 0x2FFF.
- srst asserted mid-fill at x=20, y=7 -> next cycle fill_busy=0, no fill_done, no further ram_we. A subsequent fill_start is accepted normally.

Source files
------------

// File: rtl/le18_port_arb.sv
// le18_port_arb: owns port A of the LE18 graphics RAM. Z80 single-byte
// accesses always win; the row-range fill engine only writes on cycles the
// Z80 and the read pipeline leave free.

// Protocol checker: a new Z80 request must not land on a pending slot that is
// still occupied and not being issued this cycle.
module le18_port_arb_chk (
  input logic clk,
  input logic srst,
  input logic z80_req,
  input logic pend_full,
  input logic pend_issue
);
  a_no_pend_overrun: assert property (@(posedge clk) disable iff (srst)
    !(z80_req && pend_full && !pend_issue));
endmodule

module le18_port_arb #(
  parameter int DW    = 6,
  parameter int XW    = 6,
  parameter int Y_MAX = 191
) (
  input  logic           clk,
  input  logic           srst,
  input  logic           z80_req,
  input  logic           z80_we,
  input  logic [XW+7:0]  z80_addr,
  input  logic [DW-1:0]  z80_din,
  output logic [DW-1:0]  z80_dout,
  output logic           z80_rdy,
  input  logic           fill_start,
  input  logic [DW-1:0]  fill_val,
  input  logic [7:0]     fill_y0,
  input  logic [7:0]     fill_y1,
  output logic           fill_busy,
  output logic           fill_done,
  output logic           ram_ce,
  output logic           ram_we,
  output logic [XW+7:0]  ram_addr,
  output logic [DW-1:0]  ram_din,
  output logic           ram_oce,
  input  logic [DW-1:0]  ram_dout
);

  localparam logic [7:0]    Y_MAX_C = 8'(Y_MAX);
  localparam logic [XW-1:0] X_LAST  = {XW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  fill_state_e   state_q, state_d;
  logic          rd1_q, rd1_d;      // read at T+1: output-register enable
  logic          rd2_q, rd2_d;      // read at T+2: data valid
  logic          pend_v_q, pend_v_d;
  logic          pend_we_q, pend_we_d;
  logic [XW+7:0] pend_addr_q, pend_addr_d;
  logic [DW-1:0] pend_din_q, pend_din_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [DW-1:0] fill_val_q, fill_val_d;
  logic [7:0]    y_q, y_d;
  logic [7:0]    yend_q, yend_d;
  logic [XW-1:0] x_q, x_d;

  logic          port_free_s;
  logic          z_go_s;
  logic          z_we_s;
  logic [XW+7:0] z_addr_s;
  logic [DW-1:0] z_din_s;
  logic          fill_go_s;
  logic [7:0]    y0_s, y1_s;

  function automatic logic [7:0] clamp_row(input logic [7:0] row);
    if (row > Y_MAX_C) begin
      return Y_MAX_C;
    end else begin
      return row;
    end
  endfunction

  // Arbitration: pending request first, then a live request, then the fill.
  always_comb begin
    port_free_s = ~srst & ~rd1_q & ~rd2_q;
    z_go_s      = port_free_s & (pend_v_q | z80_req);
    if (pend_v_q) begin
      z_we_s   = pend_we_q;
      z_addr_s = pend_addr_q;
      z_din_s  = pend_din_q;
    end else begin
      z_we_s   = z80_we;
      z_addr_s = z80_addr;
      z_din_s  = z80_din;
    end
    fill_go_s = port_free_s & ~z_go_s & (state_q == ST_FILL);
  end

  // Pending slot and read pipeline next state; a request not issued directly is parked.
  always_comb begin
    pend_v_d    = pend_v_q;
    pend_we_d   = pend_we_q;
    pend_addr_d = pend_addr_q;
    pend_din_d  = pend_din_q;
    if (z80_req && !(z_go_s && !pend_v_q)) begin
      pend_v_d    = 1'b1;
      pend_we_d   = z80_we;
      pend_addr_d = z80_addr;
      pend_din_d  = z80_din;
    end else if (z_go_s) begin
      pend_v_d = 1'b0;
    end else begin
      pend_v_d = pend_v_q;
    end
    rd1_d = z_go_s & ~z_we_s;
    rd2_d = rd1_q;
    if (rd2_q) begin
      dout_d = ram_dout;
    end else begin
      dout_d = dout_q;
    end
  end

  // Fill FSM next state: latch and clamp the range, then walk {y, x} on free cycles.
  always_comb begin
    y0_s       = clamp_row(fill_y0);
    y1_s       = clamp_row(fill_y1);
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    yend_d     = yend_q;
    fill_val_d = fill_val_q;
    case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          fill_val_d = fill_val;
          y_d        = y0_s;
          yend_d     = y1_s;
          x_d        = '0;
          if (y0_s > y1_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (fill_go_s) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == yend_q) begin
              state_d = ST_DONE;
            end else begin
              y_d = y_q + 8'd1;
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any fill silently.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= ST_IDLE;
      rd1_q       <= 1'b0;
      rd2_q       <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_we_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_din_q  <= '0;
      dout_q      <= '0;
      fill_val_q  <= '0;
      y_q         <= 8'd0;
      yend_q      <= 8'd0;
      x_q         <= '0;
    end else begin
      state_q     <= state_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      pend_v_q    <= pend_v_d;
      pend_we_q   <= pend_we_d;
      pend_addr_q <= pend_addr_d;
      pend_din_q  <= pend_din_d;
      dout_q      <= dout_d;
      fill_val_q  <= fill_val_d;
      y_q         <= y_d;
      yend_q      <= yend_d;
      x_q         <= x_d;
    end
  end

  // Port A drive: address and data are forced to zero on idle cycles.
  always_comb begin
    ram_ce = z_go_s | fill_go_s;
    ram_we = (z_go_s & z_we_s) | fill_go_s;
    if (z_go_s) begin
      ram_addr = z_addr_s;
    end else if (fill_go_s) begin
      ram_addr = {y_q, x_q};
    end else begin
      ram_addr = '0;
    end
    if (z_go_s && z_we_s) begin
      ram_din = z_din_s;
    end else if (fill_go_s) begin
      ram_din = fill_val_q;
    end else begin
      ram_din = '0;
    end
    ram_oce   = rd1_q;
    z80_rdy   = rd2_q;
    z80_dout  = rd2_q ? ram_dout : dout_q;
    fill_busy = (state_q != ST_IDLE);
    fill_done = (state_q == ST_DONE);
  end

  le18_port_arb_chk u_chk (
    .clk        (clk),
    .srst       (srst),
    .z80_req    (z80_req),
    .pend_full  (pend_v_q),
    .pend_issue (z_go_s)
  );

endmodule
